// File: rtl/seg_pkg.sv
`default_nettype none
//============================================================================
// seg_pkg - seven-segment constants and scan slot type | Rev 1.0
//============================================================================
package seg_pkg;

  // Active-low segment patterns {g,f,e,d,c,b,a}, entry n = hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
//============================================================================
// seg_hex_decode - hex nibble to active-low seven-segment pattern | Rev 1.0
//============================================================================
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctl.sv
`default_nettype none
//============================================================================
// seg_scan_ctl - 4-digit multiplexed 7-seg scan with guard and frame buffer
// Rev 1.0
//============================================================================
module seg_scan_ctl
  import seg_pkg::*;
#(
  parameter int DIV_W     = 18,
  parameter int GUARD_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  ssd_an,
  output logic [7:0]  ssd_seg,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] GUARD_LIM = DIV_W'(GUARD_CYC);

  logic [DIV_W-1:0] cnt;
  slot_e            slot;
  slot_e            slot_nxt;
  logic             tick;
  logic             boundary;

  logic [15:0]      stage_bcd;
  logic [3:0]       stage_dp;
  logic [3:0]       stage_en;
  logic             pending;
  logic [15:0]      shadow_bcd;
  logic [3:0]       shadow_dp;
  logic [3:0]       shadow_en;

  logic [1:0]       sel;
  logic [3:0]       nibble;
  logic [6:0]       hex_seg;
  logic [3:0]       an_nxt;
  logic [7:0]       seg_nxt;

  assign tick     = &cnt;
  assign boundary = tick && (slot == SLOT3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      slot <= SLOT0;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      slot <= slot_nxt;
    end
  end

  always_comb begin
    slot_nxt = slot;
    if (tick) begin
      case (slot)
        SLOT0:   slot_nxt = SLOT1;
        SLOT1:   slot_nxt = SLOT2;
        SLOT2:   slot_nxt = SLOT3;
        SLOT3:   slot_nxt = SLOT0;
        default: slot_nxt = SLOT0;
      endcase
    end
  end

  // A load coinciding with the boundary bypasses staging so it is not lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_bcd  <= '0;
      stage_dp   <= '0;
      stage_en   <= '0;
      pending    <= 1'b0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      shadow_en  <= '0;
    end else begin
      if (load) begin
        stage_bcd <= bcd_in;
        stage_dp  <= dp_in;
        stage_en  <= digit_en;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          shadow_bcd <= bcd_in;
          shadow_dp  <= dp_in;
          shadow_en  <= digit_en;
        end else if (pending) begin
          shadow_bcd <= stage_bcd;
          shadow_dp  <= stage_dp;
          shadow_en  <= stage_en;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign sel    = slot;
  assign nibble = shadow_bcd[{sel, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    if ((cnt >= GUARD_LIM) && shadow_en[sel]) begin
      an_nxt  = ~(4'b0001 << sel);
      seg_nxt = {~shadow_dp[sel], hex_seg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssd_an     <= AN_OFF;
      ssd_seg    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      ssd_an     <= an_nxt;
      ssd_seg    <= seg_nxt;
      frame_done <= boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctl.sv
`default_nettype none
//============================================================================
// tb_seg_scan_ctl - vector table plus cycle scoreboard for seg_scan_ctl
// Rev 1.0
//============================================================================
module tb_seg_scan_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  ssd_an;
  logic [7:0]  ssd_seg;
  logic        frame_done;

  seg_scan_ctl #(.DIV_W(4), .GUARD_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .ssd_an     (ssd_an),
    .ssd_seg    (ssd_seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Display patterns straight from the datasheet table, dp off
  logic [7:0] hex8 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;
  exp_t q[$];

  // Reference model of the scan behaviour; pushes the value due on the pins
  int          m_cnt = 0;
  int          m_idx = 0;
  logic        m_pend = 1'b0;
  logic [15:0] m_stg_bcd = '0, m_sh_bcd = '0;
  logic [3:0]  m_stg_dp = '0, m_stg_en = '0, m_sh_dp = '0, m_sh_en = '0;

  always @(posedge clk or posedge rst) begin
    exp_t e;
    logic bnd;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pend = 1'b0;
      m_stg_bcd = '0; m_stg_dp = '0; m_stg_en = '0;
      m_sh_bcd = '0; m_sh_dp = '0; m_sh_en = '0;
      q.delete();
    end else begin
      bnd = (m_cnt == 15) && (m_idx == 3);
      e.an = 4'hF; e.seg = 8'hFF; e.fd = bnd;
      if (m_cnt >= 2 && m_sh_en[m_idx]) begin
        e.an = 4'hF;
        e.an[m_idx] = 1'b0;
        e.seg = hex8[m_sh_bcd[m_idx*4 +: 4]];
        if (m_sh_dp[m_idx]) e.seg[7] = 1'b0;
      end
      q.push_back(e);
      if (bnd && load) begin
        m_sh_bcd = bcd_in; m_sh_dp = dp_in; m_sh_en = digit_en; m_pend = 1'b0;
      end else if (bnd && m_pend) begin
        m_sh_bcd = m_stg_bcd; m_sh_dp = m_stg_dp; m_sh_en = m_stg_en; m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      if (load) begin
        m_stg_bcd = bcd_in; m_stg_dp = dp_in; m_stg_en = digit_en;
      end
      if (m_cnt == 15) m_idx = (m_idx + 1) % 4;
      m_cnt = (m_cnt + 1) % 16;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_an", ssd_an, 4'hF);
      chk("rst_seg", ssd_seg, 8'hFF);
      chk("rst_fd", frame_done, 1'b0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_an", ssd_an, e.an);
      chk("sb_seg", ssd_seg, e.seg);
      chk("sb_fd", frame_done, e.fd);
      chk("an_onehot", ($countones(~ssd_an) <= 1), 1'b1);
    end
  end

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 300);
    if (frame_done !== 1'b1) chk("fd_wait", frame_done, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] en);
    @(posedge clk); #1;
    load = 1'b1; bcd_in = b; dp_in = d; digit_en = en;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic [3:0][3:0] an;
    logic [3:0][7:0] seg;
  } vec_t;
  vec_t vt [4];

  initial begin
    int n;
    vt[0] = '{bcd:16'h1234, dp:4'h0, en:4'hF,
              an:{4'h7, 4'hB, 4'hD, 4'hE}, seg:{8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vt[1] = '{bcd:16'h000A, dp:4'h1, en:4'h5,
              an:{4'hF, 4'hB, 4'hF, 4'hE}, seg:{8'hFF, 8'hC0, 8'hFF, 8'h08}};
    vt[2] = '{bcd:16'h8F0B, dp:4'hA, en:4'hE,
              an:{4'h7, 4'hB, 4'hD, 4'hF}, seg:{8'h00, 8'h8E, 8'h40, 8'hFF}};
    vt[3] = '{bcd:16'h9C5D, dp:4'h4, en:4'h9,
              an:{4'h7, 4'hF, 4'hF, 4'hE}, seg:{8'h90, 8'hFF, 8'hFF, 8'hA1}};

    rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; digit_en = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", ssd_an, 4'hF);
    chk("reset_seg", ssd_seg, 8'hFF);
    chk("reset_fd", frame_done, 1'b0);
    rst = 1'b0;

    // Idle: blank display and a steady 64-clock frame
    wait_fd(n);
    for (int i = 0; i < 3; i++) begin
      wait_fd(n);
      chk("fd_period", n, 64);
      chk("idle_an", ssd_an, 4'hF);
    end

    // Table vectors: load mid-frame, check the middle of every slot next frame
    for (int v = 0; v < 4; v++) begin
      wait_fd(n);
      do_load(vt[v].bcd, vt[v].dp, vt[v].en);
      wait_fd(n);
      for (int s = 0; s < 4; s++) begin
        repeat (s == 0 ? 9 : 16) @(negedge clk);
        chk($sformatf("vec%0d_an%0d", v, s), ssd_an, vt[v].an[s]);
        chk($sformatf("vec%0d_seg%0d", v, s), ssd_seg, vt[v].seg[s]);
      end
    end

    // Several loads in one frame: the last one is shown
    wait_fd(n);
    do_load(16'h1111, 4'h0, 4'hF);
    repeat (10) @(posedge clk);
    do_load(16'h2222, 4'h0, 4'hF);
    wait_fd(n);
    repeat (9) @(negedge clk);
    chk("last_wins_seg", ssd_seg, 8'hA4);

    // Load in the boundary cycle goes straight to the shadow
    do_load(16'h1111, 4'h0, 4'hF);
    wait_fd(n);
    repeat (63) @(posedge clk);
    #1;
    load = 1'b1; bcd_in = 16'h3333; dp_in = 4'h0; digit_en = 4'hF;
    @(posedge clk); #1;
    load = 1'b0;
    wait_fd(n);
    chk("bypass_fd_latency", n, 1);
    chk("bypass_pending", dut.pending, 1'b0);
    repeat (9) @(negedge clk);
    chk("bypass_seg", ssd_seg, 8'hB0);

    // Asynchronous reset in slot 2 with a load still pending
    do_load(16'h5555, 4'h0, 4'hF);
    repeat (24) @(posedge clk);
    #2;
    chk("pre_rst_an", ssd_an, 4'b1011);
    rst = 1'b1;
    #1;
    chk("async_rst_an", ssd_an, 4'hF);
    chk("async_rst_seg", ssd_seg, 8'hFF);
    chk("async_rst_pending", dut.pending, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      wait_fd(n);
      repeat (9) @(negedge clk);
      chk("post_rst_blank_an", ssd_an, 4'hF);
      chk("post_rst_blank_seg", ssd_seg, 8'hFF);
    end
    do_load(16'h4321, 4'h0, 4'hF);
    wait_fd(n);
    repeat (9) @(negedge clk);
    chk("post_rst_load_an", ssd_an, 4'hE);
    chk("post_rst_load_seg", ssd_seg, 8'hF9);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
